// File: rtl/modmul_173_pkg.sv
// Shared constants and state encoding for the GF(173) shift-add multiplier.
package modmul_173_pkg;

    localparam int P  = 173;
    localparam int W  = 8;
    localparam int PW = 15;
    localparam int CW = $clog2(W);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add iteration: conditional accumulate, shift multiplicand left, multiplier right.
// Latency: combinational.
// Backpressure: none, pure datapath.
module shift_add_step
    import modmul_173_pkg::*;
(
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] a_sh,
    input  logic [W-1:0]  b_sh,
    output logic [PW-1:0] acc_nxt,
    output logic [PW-1:0] a_sh_nxt,
    output logic [W-1:0]  b_sh_nxt
);

    assign acc_nxt  = b_sh[0] ? acc + a_sh : acc;
    assign a_sh_nxt = a_sh << 1;
    assign b_sh_nxt = b_sh >> 1;

endmodule

// File: rtl/modmul_shift_add_173.sv
// Sequential 8x8 -> 15-bit multiplier feeding the mod-173 reducer; OPERAND_CHECK_EN adds range_err.
// Latency: result valid W cycles after acceptance; initiation interval W+2.
// Backpressure: result held in DONE until out_ready; in_ready only asserted in IDLE.
module modmul_shift_add_173
    import modmul_173_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din_a,
    input  logic [W-1:0]  din_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] dout_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
`ifdef OPERAND_CHECK_EN
    ,
    output logic          range_err
`endif
);

    state_t        state;
    logic [PW-1:0] acc;
    logic [PW-1:0] a_sh;
    logic [W-1:0]  b_sh;
    logic [CW-1:0] cnt;

    logic [PW-1:0] acc_nxt;
    logic [PW-1:0] a_sh_nxt;
    logic [W-1:0]  b_sh_nxt;

    shift_add_step u_step (
        .acc      (acc),
        .a_sh     (a_sh),
        .b_sh     (b_sh),
        .acc_nxt  (acc_nxt),
        .a_sh_nxt (a_sh_nxt),
        .b_sh_nxt (b_sh_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= PW'(din_a);
                        b_sh  <= din_b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh_nxt;
                    b_sh <= b_sh_nxt;
                    cnt  <= cnt + CW'(1);
                    // Fixed latency: no early exit when the multiplier runs out of ones.
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OPERAND_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            range_err <= (din_a >= W'(P)) | (din_b >= W'(P));
        end else if (state == DONE && out_ready) begin
            range_err <= 1'b0;
        end
    end
`endif

    // State is IDLE during reset, so gate in_ready explicitly to keep it low.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);
    assign dout_p    = acc;

endmodule

// File: tb/tb_modmul_shift_add_173.sv
// Randomized self-checking bench for modmul_shift_add_173 against an arithmetic reference.
module tb_modmul_shift_add_173;
    import modmul_173_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din_a = '0;
    logic [W-1:0]  din_b = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] dout_p;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
`ifdef OPERAND_CHECK_EN
    logic          range_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    modmul_shift_add_173 dut (
        .clk       (clk),
        .rst       (rst),
        .din_a     (din_a),
        .din_b     (din_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout_p    (dout_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef OPERAND_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles out_ready stays low after out_valid appears.
    task automatic run_op(input int a, input int b, input int hold);
        int lat;
        bit seen;
        int exp_p;
        logic [PW-1:0] first_p;
        exp_p = (a * b) % (1 << PW);

        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        chk("ready_before_op", 32'(in_ready), 1);

        din_a     = a[W-1:0];
        din_b     = b[W-1:0];
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        chk("in_ready_low_after_accept", 32'(in_ready), 0);
        chk("busy_after_accept", 32'(busy), 1);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            // Operand lines are garbage while busy; they must not disturb the result.
            in_valid = 1'($urandom_range(0, 1));
            din_a    = W'($urandom);
            din_b    = W'($urandom);
            tick();
            lat++;
            seen = out_valid;
            if (!seen) chk("in_ready_low_in_busy", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(W));
        chk("product", 32'(dout_p), 32'(exp_p));
        chk("reduced", 32'(dout_p) % 32'(P), 32'(exp_p % P));
`ifdef OPERAND_CHECK_EN
        chk("range_err", 32'(range_err), 32'((a >= P) || (b >= P)));
`endif
        first_p = dout_p;

        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(dout_p), 32'(first_p));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("valid_drop_on_consume", 32'(out_valid), 0);
        chk("idle_after_consume", 32'(in_ready), 1);
        chk("busy_after_consume", 32'(busy), 0);
`ifdef OPERAND_CHECK_EN
        chk("range_err_cleared", 32'(range_err), 0);
`endif
        out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_mid_busy();
        int spurious;
        int lat;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        din_a     = 8'd7;
        din_b     = 8'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_dout", 32'(dout_p), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 1);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        chk("no_spurious_valid", 32'(spurious), 0);
    endtask

    initial begin
        #2;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_dout", 32'(dout_p), 0);
        chk("reset_busy", 32'(busy), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);
        chk("post_reset_busy", 32'(busy), 0);

        run_op(0, 0, 0);
        run_op(172, 172, 0);
        run_op(13, 11, 1);
        run_op(100, 50, 5);
        reset_mid_busy();
        run_op(2, 3, 0);
        run_op(200, 3, 0);
        run_op(172, 1, 0);
        run_op(0, 172, 2);
        run_op(172, 0, 0);
        run_op(1, 1, 0);
        run_op(255, 255, 0);

        repeat (1500) begin
            int a;
            int b;
            int h;
            a = $urandom_range(0, P - 1);
            b = $urandom_range(0, P - 1);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(a, b, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/modmul_shift_add_173.md
Name: modmul_shift_add_173

Overview:
Sequential radix-2 shift-add multiplier for GF(173) operands.
- Accepts two 8-bit residues and produces their 15-bit integer product.
- Sits directly upstream of the combinational Barrett reducer for 173: dout_p drives the reducer's 15-bit din_a.
- Valid/ready handshakes on both sides, so it can sit in a streaming datapath with backpressure.

Parameters:
P, 173, modulus; legal operands are 0..P-1
W, 8, operand width in bits; equals iteration count
PW, 15, product width; ceil(log2((P-1)^2+1)) = 15 for P=173

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
din_a  in  W  multiplicand, must be < P
din_b  in  W  multiplier, must be < P
in_valid  in  1  operands present
in_ready  out  1  block can accept operands (high only in IDLE)
dout_p  out  PW  product din_a*din_b, stable while out_valid
out_valid  out  1  product available
out_ready  in  1  consumer takes product
busy  out  1  high in BUSY or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high, all of the following are forced immediately:
  - state = IDLE
  - in_ready = 0
  - out_valid = 0
  - dout_p = 0
  - busy = 0
  - internal accumulator, shift registers and counter = 0
- After rst deasserts: in_ready = 1 from the first cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid = 1:
    - latch a_sh = din_a zero-extended to PW bits; latch b_sh = din_b
    - clear acc and cnt
    - go to BUSY
  - With in_valid = 0: stay in IDLE.
- BUSY: exactly W cycles. Per cycle:
  - if b_sh[0] = 1: acc <= acc + a_sh (PW-bit add, no overflow possible for legal operands)
  - a_sh <= a_sh << 1, truncated to PW bits
  - b_sh <= b_sh >> 1
  - cnt <= cnt + 1
  - when cnt = W-1: go to DONE
  - No early exit for zero operands; latency is fixed.
- DONE:
  - out_valid = 1; dout_p = acc.
  - dout_p is held unchanged until a clk edge with out_ready = 1, then go to IDLE (out_valid drops on that edge).
- Timing: operands accepted at edge k -> out_valid visible after edge k+W. Minimum initiation interval is W+2 cycles.
- in_ready = 0 in BUSY and DONE.
  - in_valid and the input data are ignored in those states.
  - No operand may be captured mid-operation.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-BUSY or mid-DONE: result is discarded, all state goes to reset values asynchronously, and no out_valid pulse appears.
- Illegal operands (>= P, up to 2^W-1):
  - The arithmetic result is the low PW bits of the true product.
  - That is only meaningful when the product is < 2^PW.
  - Downstream reduction is undefined.

Optional Feature:
OPERAND_CHECK_EN
- Defined:
  - adds output range_err (1 bit), reset 0
  - on acceptance, range_err is registered as (din_a >= P) | (din_b >= P)
  - range_err stays valid alongside out_valid, and is cleared when the result is consumed
  - the product is still computed
- Undefined: port absent, no comparators synthesised; behaviour otherwise identical.

Decomposition:
- Package modmul_173_pkg:
  - constants P, W, PW
  - state typedef (IDLE, BUSY, DONE)
  - counter width localparam, $clog2(W)
- One natural sub-module, shift_add_step (combinational). Inputs acc, a_sh, b_sh. Outputs next acc, next a_sh, next b_sh.
- FSM and registers stay in the top.

Test Plan:
- Zero product: din_a=0, din_b=0, in_valid=1 for one cycle, out_ready=1 -> out_valid high exactly W=8 cycles after acceptance; dout_p=0.
- Maximum legal product: 172*172 -> dout_p=29584 (0x7390); in_ready low from the acceptance edge until the edge after consumption.
- Typical product plus downstream check: 13*11 -> dout_p=143; the reducer fed dout_p returns 143. Sweep all a,b in 0..172 against a*b, and chain through the reducer against (a*b) mod 173.
- Backpressure: 100*50 with out_ready held low for 5 cycles after out_valid -> dout_p stays 5000 and out_valid stays 1 throughout; IDLE entered on the first edge with out_ready=1.
- Reset mid-operation: accept 7*9, assert rst in cycle 3 of BUSY -> outputs 0 immediately; in_ready=1 after release; no spurious out_valid; next operation 2*3 -> 6.
- OPERAND_CHECK_EN: 200*3 -> range_err=1, dout_p=600; 172*1 -> range_err=0.
